csr_bus_router: RTL and testbench

//  Registered CSR request router between the core CSR stage and NUM_TGT CSR target modules (PMP, AIA, ...).

---
 rtl/csr_bus_pkg.sv | 18 +
 rtl/csr_addr_decoder.sv | 32 +++
 rtl/csr_bus_router.sv | 178 +++++++++++++++++
 tb/tb_csr_bus_router.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_bus_pkg.sv
// Shared types for the CSR bus router: op/funct3 encodings, FSM states
// and the architectural PMP CSR window.
package csr_bus_pkg;

   typedef logic [1:0] csr_op_t;
   typedef logic [2:0] csr_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RSP
   } csr_bus_state_e;

   localparam logic [11:0] CSR_ADDR_PMP_LO = 12'h3a0;
   localparam logic [11:0] CSR_ADDR_PMP_HI = 12'h3ef;

endpackage

// File: rtl/csr_addr_decoder.sv
// Range compare of a CSR address against every target window,
// lowest index wins when windows overlap.
module csr_addr_decoder #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_TGT    = 2,
   parameter int SEL_W      = 1,
   parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_BASE = '0,
   parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_LAST = '0
)(
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_TGT-1:0]    hit,
   output logic [SEL_W-1:0]      sel
);

   logic [NUM_TGT-1:0][ADDR_WIDTH:0] lo_d;
   logic [NUM_TGT-1:0][ADDR_WIDTH:0] hi_d;

   // borrow-out of the subtraction gives an unsigned compare
   for (genvar g = 0; g < NUM_TGT; g++) begin : g_cmp
      assign lo_d[g] = {1'b0, addr} - {1'b0, TGT_BASE[g]};
      assign hi_d[g] = {1'b0, TGT_LAST[g]} - {1'b0, addr};
      assign hit[g]  = ~lo_d[g][ADDR_WIDTH] & ~hi_d[g][ADDR_WIDTH];
   end

   always_comb begin
      sel = '0;
      for (int i = NUM_TGT - 1; i >= 0; i--) begin
         if (hit[i]) sel = SEL_W'(i);
      end
   end

endmodule

// File: rtl/csr_bus_router.sv
// Registered CSR request router: IDLE->ISSUE->WAIT->RSP towards NUM_TGT targets.
// Define CSR_BUS_TIMEOUT_EN to bound WAIT at TIMEOUT_CYC cycles.
module csr_bus_router
   import csr_bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int REG_WIDTH   = 32,
   parameter int NUM_TGT     = 2,
   parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_BASE =
      {ADDR_WIDTH'(12'h000), ADDR_WIDTH'(CSR_ADDR_PMP_LO)},
   parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_LAST =
      {ADDR_WIDTH'(12'h000), ADDR_WIDTH'(CSR_ADDR_PMP_HI)},
   parameter int TIMEOUT_CYC = 64
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          csr_valid,
   output logic                          csr_ready,
   input  csr_op_t                       csr_op,
   input  csr_funct3_t                   csr_funct3,
   input  logic [4:0]                    csr_imm,
   input  logic [REG_WIDTH-1:0]          rs1_val,
   input  logic [ADDR_WIDTH-1:0]         csr_addr,
   output logic                          csr_rvalid,
   output logic [ADDR_WIDTH-1:0]         csr_rdata,
   output logic                          csr_reg_rsp,
   input  logic                          csr_rrsp,
   output logic [NUM_TGT-1:0]            tgt_reg_en,
   output logic [ADDR_WIDTH-1:0]         tgt_addr,
   output csr_op_t                       tgt_reg_op,
   output csr_funct3_t                   tgt_funct3,
   output logic [4:0]                    tgt_csr_imm,
   output logic [REG_WIDTH-1:0]          tgt_rs1_val,
   input  logic [NUM_TGT-1:0]            tgt_rvalid,
   input  logic [NUM_TGT*ADDR_WIDTH-1:0] tgt_rdata,
   input  logic [NUM_TGT-1:0]            tgt_act_rsp,
   output logic [NUM_TGT-1:0]            tgt_rrsp
);

   localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

   csr_bus_state_e        state_q, state_d;
   logic [NUM_TGT-1:0]    hit;
   logic [SEL_W-1:0]      sel, sel_q;
   logic [NUM_TGT-1:0]    sel_1h;
   logic                  rsel_valid, rsel_act, timeout;
   logic [ADDR_WIDTH-1:0] rsel_data;
   logic [ADDR_WIDTH-1:0] addr_q, rdata_q;
   csr_op_t               op_q;
   csr_funct3_t           funct3_q;
   logic [4:0]            imm_q;
   logic [REG_WIDTH-1:0]  rs1_q;
   logic                  rsp_q;

   csr_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_TGT    (NUM_TGT),
      .SEL_W      (SEL_W),
      .TGT_BASE   (TGT_BASE),
      .TGT_LAST   (TGT_LAST)
   ) u_dec (
      .addr (csr_addr),
      .hit  (hit),
      .sel  (sel)
   );

   always_comb begin
      sel_1h    = '0;
      rsel_data = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         sel_1h[i] = (sel_q == SEL_W'(i));
         if (sel_1h[i]) rsel_data = tgt_rdata[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      rsel_valid = |(sel_1h & tgt_rvalid);
      rsel_act   = |(sel_1h & tgt_act_rsp);
   end

`ifdef CSR_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_q <= '0;
      else if (state_q == ISSUE) cnt_q <= '0;
      else if (state_q == WAIT)  cnt_q <= cnt_q + 1'b1;
   end

   assign timeout = (state_q == WAIT) && !rsel_valid &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (csr_valid) state_d = (|hit) ? ISSUE : RSP;
         ISSUE: state_d = WAIT;
         WAIT:  if (rsel_valid || timeout) state_d = RSP;
         RSP:   if (csr_rrsp) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         op_q     <= '0;
         funct3_q <= '0;
         imm_q    <= '0;
         rs1_q    <= '0;
         sel_q    <= '0;
         rdata_q  <= '0;
         rsp_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (csr_valid) begin
               addr_q   <= csr_addr;
               op_q     <= csr_op;
               funct3_q <= csr_funct3;
               imm_q    <= csr_imm;
               rs1_q    <= rs1_val;
               sel_q    <= sel;
               rdata_q  <= '0;
               rsp_q    <= ~|hit;
            end
            WAIT: if (rsel_valid) begin
               rdata_q <= rsel_data;
               rsp_q   <= rsel_act;
            end else if (timeout) begin
               rdata_q <= '0;
               rsp_q   <= 1'b1;
            end
            RSP: if (csr_rrsp) begin
               rdata_q <= '0;
               rsp_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_ready   = 1'b0;
      tgt_reg_en  = '0;
      tgt_addr    = '0;
      tgt_reg_op  = '0;
      tgt_funct3  = '0;
      tgt_csr_imm = '0;
      tgt_rs1_val = '0;
      tgt_rrsp    = '0;
      unique case (state_q)
         IDLE:  csr_ready = 1'b1;
         ISSUE: begin
            tgt_reg_en  = sel_1h;
            tgt_addr    = addr_q;
            tgt_reg_op  = op_q;
            tgt_funct3  = funct3_q;
            tgt_csr_imm = imm_q;
            tgt_rs1_val = rs1_q;
         end
         WAIT:  tgt_rrsp = sel_1h & tgt_rvalid;
         default: ;
      endcase
   end

   assign csr_rvalid  = (state_q == RSP);
   assign csr_rdata   = rdata_q;
   assign csr_reg_rsp = rsp_q;

endmodule

// File: tb/tb_csr_bus_router.sv
// Directed bench for csr_bus_router with a range-table routing model
// and a per-cycle output compare.
module tb_csr_bus_router;

   localparam int AW = 32;
   localparam int RW = 32;
   localparam int NT = 2;
   // tgt1 = PMP window, tgt0 overlaps its top to exercise priority
   localparam logic [NT-1:0][AW-1:0] BASE = {32'h0000_03a0, 32'h0000_03e0};
   localparam logic [NT-1:0][AW-1:0] LAST = {32'h0000_03ef, 32'h0000_03ff};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             csr_valid = 1'b0;
   logic             csr_ready;
   logic [1:0]       csr_op = '0;
   logic [2:0]       csr_funct3 = '0;
   logic [4:0]       csr_imm = '0;
   logic [RW-1:0]    rs1_val = '0;
   logic [AW-1:0]    csr_addr = '0;
   logic             csr_rvalid;
   logic [AW-1:0]    csr_rdata;
   logic             csr_reg_rsp;
   logic             csr_rrsp = 1'b0;
   logic [NT-1:0]    tgt_reg_en;
   logic [AW-1:0]    tgt_addr;
   logic [1:0]       tgt_reg_op;
   logic [2:0]       tgt_funct3;
   logic [4:0]       tgt_csr_imm;
   logic [RW-1:0]    tgt_rs1_val;
   logic [NT-1:0]    tgt_rvalid = '0;
   logic [NT*AW-1:0] tgt_rdata = '0;
   logic [NT-1:0]    tgt_act_rsp = '0;
   logic [NT-1:0]    tgt_rrsp;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit pinned = 1'b0;

   logic          exp_ready, exp_rvalid, exp_rsp;
   logic [AW-1:0] exp_rdata, exp_addr;
   logic [NT-1:0] exp_en, exp_rrsp;
   logic [1:0]    exp_op;
   logic [2:0]    exp_f3;
   logic [4:0]    exp_imm;
   logic [RW-1:0] exp_rs1;

   csr_bus_router #(
      .ADDR_WIDTH  (AW),
      .REG_WIDTH   (RW),
      .NUM_TGT     (NT),
      .TGT_BASE    (BASE),
      .TGT_LAST    (LAST),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .csr_valid   (csr_valid),
      .csr_ready   (csr_ready),
      .csr_op      (csr_op),
      .csr_funct3  (csr_funct3),
      .csr_imm     (csr_imm),
      .rs1_val     (rs1_val),
      .csr_addr    (csr_addr),
      .csr_rvalid  (csr_rvalid),
      .csr_rdata   (csr_rdata),
      .csr_reg_rsp (csr_reg_rsp),
      .csr_rrsp    (csr_rrsp),
      .tgt_reg_en  (tgt_reg_en),
      .tgt_addr    (tgt_addr),
      .tgt_reg_op  (tgt_reg_op),
      .tgt_funct3  (tgt_funct3),
      .tgt_csr_imm (tgt_csr_imm),
      .tgt_rs1_val (tgt_rs1_val),
      .tgt_rvalid  (tgt_rvalid),
      .tgt_rdata   (tgt_rdata),
      .tgt_act_rsp (tgt_act_rsp),
      .tgt_rrsp    (tgt_rrsp)
   );

   always #5 clk = ~clk;

   // first window in index order that contains the address, -1 on miss
   function automatic int route(input logic [AW-1:0] a);
      for (int i = 0; i < NT; i++)
         if (a >= BASE[i] && a <= LAST[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (!pinned) begin
            pinned = 1'b1;
            chk("pin_pmp_tgt1", 64'(route(32'h3a0)), 64'd1);
            chk("pin_overlap_tgt0", 64'(route(32'h3e8)), 64'd0);
            chk("pin_unmapped", 64'(route(32'h7c0) + 1), 64'd0);
            chk("pin_below_pmp", 64'(route(32'h39f) + 1), 64'd0);
         end
         chk("csr_ready", 64'(csr_ready), 64'(exp_ready));
         chk("csr_rvalid", 64'(csr_rvalid), 64'(exp_rvalid));
         chk("csr_rdata", 64'(csr_rdata), 64'(exp_rdata));
         chk("csr_reg_rsp", 64'(csr_reg_rsp), 64'(exp_rsp));
         chk("tgt_reg_en", 64'(tgt_reg_en), 64'(exp_en));
         chk("tgt_addr", 64'(tgt_addr), 64'(exp_addr));
         chk("tgt_reg_op", 64'(tgt_reg_op), 64'(exp_op));
         chk("tgt_funct3", 64'(tgt_funct3), 64'(exp_f3));
         chk("tgt_csr_imm", 64'(tgt_csr_imm), 64'(exp_imm));
         chk("tgt_rs1_val", 64'(tgt_rs1_val), 64'(exp_rs1));
         chk("tgt_rrsp", 64'(tgt_rrsp), 64'(exp_rrsp));
      end
   end

   task automatic exp_busy();
      exp_ready  = 1'b0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      exp_rsp    = 1'b0;
      exp_en     = '0;
      exp_addr   = '0;
      exp_op     = '0;
      exp_f3     = '0;
      exp_imm    = '0;
      exp_rs1    = '0;
      exp_rrsp   = '0;
   endtask

   task automatic exp_idle();
      exp_busy();
      exp_ready = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic [AW-1:0] a, input logic [1:0] op,
                      input logic [2:0] f3, input logic [4:0] imm,
                      input logic [RW-1:0] rs1, input int lat,
                      input logic [AW-1:0] rd, input logic act,
                      input int hold, input bit stray);
      int s;
      logic [AW-1:0] r_data;
      logic r_rsp;
      s = route(a);
      csr_valid  = 1'b1;
      csr_addr   = a;
      csr_op     = op;
      csr_funct3 = f3;
      csr_imm    = imm;
      rs1_val    = rs1;
      exp_idle();
      step();
      csr_valid  = 1'b0;
      csr_addr   = ~a;
      csr_op     = ~op;
      csr_funct3 = ~f3;
      csr_imm    = ~imm;
      rs1_val    = ~rs1;
      if (s >= 0) begin
         exp_busy();
         exp_en   = NT'(1 << s);
         exp_addr = a;
         exp_op   = op;
         exp_f3   = f3;
         exp_imm  = imm;
         exp_rs1  = rs1;
         step();
         for (int k = 2; k <= lat; k++) begin
            exp_busy();
            tgt_rvalid  = '0;
            tgt_act_rsp = '0;
            tgt_rdata   = '0;
            if (stray && k == 2) begin
               tgt_rvalid[1-s]           = 1'b1;
               tgt_act_rsp[1-s]          = 1'b1;
               tgt_rdata[(1-s)*AW +: AW] = 32'hbad0_bad0;
            end
            if (k == lat) begin
               tgt_rvalid[s]        = 1'b1;
               tgt_act_rsp[s]       = act;
               tgt_rdata[s*AW +: AW] = rd;
               exp_rrsp             = NT'(1 << s);
            end
            step();
         end
         tgt_rvalid  = '0;
         tgt_act_rsp = '0;
         tgt_rdata   = '0;
         r_data = rd;
         r_rsp  = act;
      end else begin
         r_data = '0;
         r_rsp  = 1'b1;
      end
      for (int h = 0; h <= hold; h++) begin
         exp_busy();
         exp_rvalid = 1'b1;
         exp_rdata  = r_data;
         exp_rsp    = r_rsp;
         csr_valid  = (h < hold);
         csr_addr   = 32'h3a4;
         csr_rrsp   = (h == hold);
         step();
      end
      csr_valid = 1'b0;
      csr_rrsp  = 1'b0;
   endtask

   initial begin
      exp_idle();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;

      txn(32'h3a0, 2'b10, 3'b010, 5'h00, 32'h0, 3, 32'hdead_beef, 1'b0, 0, 1'b0);
      txn(32'h7c0, 2'b11, 3'b001, 5'h00, 32'h1234, 0, 32'h0, 1'b0, 0, 1'b0);
      txn(32'h3b0, 2'b01, 3'b001, 5'h00, 32'hcafe_f00d, 2, 32'h55, 1'b1, 3, 1'b0);
      txn(32'h3ef, 2'b10, 3'b011, 5'h0a, 32'h7, 4, 32'h1111_2222, 1'b0, 0, 1'b1);
      txn(32'h3e8, 2'b11, 3'b111, 5'h1f, 32'h8000_0001, 2, 32'ha5a5_0f0f, 1'b0, 1, 1'b0);
      txn(32'h3ff, 2'b01, 3'b101, 5'h11, 32'hffff_ffff, 3, 32'h0bad_cafe, 1'b0, 0, 1'b1);
      txn(32'h39f, 2'b10, 3'b010, 5'h00, 32'h0, 0, 32'h0, 1'b0, 1, 1'b0);
      txn(32'h400, 2'b10, 3'b010, 5'h00, 32'h0, 0, 32'h0, 1'b0, 0, 1'b0);

      // reset in the middle of a WAIT drops the transaction
      csr_valid = 1'b1;
      csr_addr  = 32'h3a0;
      csr_op    = 2'b10;
      csr_funct3 = 3'b010;
      csr_imm   = 5'h00;
      rs1_val   = 32'h0;
      exp_idle();
      step();
      csr_valid = 1'b0;
      exp_busy();
      exp_en   = 2'b10;
      exp_addr = 32'h3a0;
      exp_op   = 2'b10;
      exp_f3   = 3'b010;
      step();
      exp_busy();
      step();
      rst_n = 1'b0;
      exp_idle();
      step();
      rst_n = 1'b1;
      tgt_rvalid = 2'b10;
      tgt_rdata[AW +: AW] = 32'h1357_9bdf;
      exp_idle();
      step();
      tgt_rvalid = '0;
      tgt_rdata  = '0;
      exp_idle();
      step();
      txn(32'h3c0, 2'b10, 3'b110, 5'h03, 32'h42, 2, 32'h2468_ace0, 1'b0, 0, 1'b0);

`ifdef CSR_BUS_TIMEOUT_EN
      csr_valid = 1'b1;
      csr_addr  = 32'h3a0;
      csr_op    = 2'b10;
      csr_funct3 = 3'b010;
      csr_imm   = 5'h00;
      rs1_val   = 32'h0;
      exp_idle();
      step();
      csr_valid = 1'b0;
      exp_busy();
      exp_en   = 2'b10;
      exp_addr = 32'h3a0;
      exp_op   = 2'b10;
      exp_f3   = 3'b010;
      step();
      for (int w = 0; w < 8; w++) begin
         exp_busy();
         step();
      end
      tgt_rvalid = 2'b10;
      tgt_rdata[AW +: AW] = 32'hfeed_0001;
      exp_busy();
      exp_rvalid = 1'b1;
      exp_rsp    = 1'b1;
      step();
      tgt_rvalid = '0;
      tgt_rdata  = '0;
      csr_rrsp   = 1'b1;
      step();
      csr_rrsp = 1'b0;
      exp_idle();
      step();
`endif

      exp_idle();
      step();
      step();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
